window3x3_gen: RTL

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

---
 rtl/window3x3_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two row delay lines.
// Optional frame_done output compiled in with macro WIN3X3_FRAME_DONE_EN.
module window3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 97,
    parameter int IMG_HEIGHT = 97
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [9*DATA_WIDTH-1:0] win_out,
    output logic                    valid_out
`ifdef WIN3X3_FRAME_DONE_EN
    ,
    output logic                    frame_done
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] mid_line [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] top_line [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] top_sr [2];
    logic [DATA_WIDTH-1:0] mid_sr [2];
    logic [DATA_WIDTH-1:0] cur_sr [2];

    logic [DATA_WIDTH-1:0] mid_tap;
    logic [DATA_WIDTH-1:0] top_tap;
    logic                  last_col;
    logic                  last_row;
    logic                  win_ready;

    // The newest column of the window is taken straight from the taps, so the
    // column shift registers only need to keep the two older columns.
    always_comb begin
        mid_tap   = mid_line[IMG_WIDTH-1];
        top_tap   = top_line[IMG_WIDTH-1];
        last_col  = (col == CW'(IMG_WIDTH - 1));
        last_row  = (row == RW'(IMG_HEIGHT - 1));
        win_ready = valid_in && (row >= RW'(2)) && (col >= CW'(2));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col       <= '0;
            row       <= '0;
            win_out   <= '0;
            valid_out <= 1'b0;
            for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
                mid_line[i] <= '0;
                top_line[i] <= '0;
            end
            for (int unsigned j = 0; j < 2; j++) begin
                top_sr[j] <= '0;
                mid_sr[j] <= '0;
                cur_sr[j] <= '0;
            end
        end else begin
            valid_out <= win_ready;
            if (valid_in) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                mid_line[0] <= data_in;
                top_line[0] <= mid_tap;
                for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
                    mid_line[i] <= mid_line[i-1];
                    top_line[i] <= top_line[i-1];
                end
                cur_sr[0] <= data_in;
                cur_sr[1] <= cur_sr[0];
                mid_sr[0] <= mid_tap;
                mid_sr[1] <= mid_sr[0];
                top_sr[0] <= top_tap;
                top_sr[1] <= top_sr[0];
            end
            if (win_ready) begin
                win_out <= {data_in, cur_sr[0], cur_sr[1],
                            mid_tap, mid_sr[0], mid_sr[1],
                            top_tap, top_sr[0], top_sr[1]};
            end
        end
    end

`ifdef WIN3X3_FRAME_DONE_EN
    // Last pixel of the frame always completes a window since both dimensions are >= 3.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= valid_in && last_col && last_row;
        end
    end
`endif

endmodule
